// File: rtl/dsi_hs_multilane_tx.sv
// Multi-lane D-PHY HS transmit sequencer: HS-GO, SYNC, payload and trail across LANES lanes in lock-step.
// Optional HS-exit guard interval after the trail is enabled by defining DSI_HS_EXIT_TIMER_EN.
module dsi_hs_multilane_tx #(
  parameter int LANES    = 4,
  parameter int CLK_MODE = 0,
  parameter int TIMER_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_rqst,
  input  logic                 fin_rqst,
  input  logic [1:0]           lane_cnt,
  input  logic [8*LANES-1:0]   inp_data,
  input  logic [TIMER_W-1:0]   hs_go_timeout,
  input  logic [TIMER_W-1:0]   hs_trail_timeout,
`ifdef DSI_HS_EXIT_TIMER_EN
  input  logic [TIMER_W-1:0]   hs_exit_timeout,
`endif
  output logic                 data_rqst,
  output logic                 active,
  output logic                 fin_ack,
  output logic [8*LANES-1:0]   hs_output,
  output logic [LANES-1:0]     hs_enable
);

  typedef enum logic [2:0] {
    IDLE,
    GO,
    SYNC,
    ACTIVE,
`ifdef DSI_HS_EXIT_TIMER_EN
    EXIT,
`endif
    TRAIL
  } state_t;

  localparam logic [1:0] MAX_LANE = 2'(LANES - 1);

  state_t               state_current, state_next;
  logic [TIMER_W-1:0]   cnt, load_val;
  logic                 load_cnt;
  logic                 trail_done;
  logic [1:0]           lane_q, lane_clamped;
  logic [LANES-1:0]     lane_en, last_b7, enable_next;
  logic [8*LANES-1:0]   out_next;

  // A zero timeout still yields one cycle in the state.
  function automatic logic [TIMER_W-1:0] load_of(input logic [TIMER_W-1:0] t);
    return (t == '0) ? '0 : t - TIMER_W'(1);
  endfunction

  assign lane_clamped = (lane_cnt > MAX_LANE) ? MAX_LANE : lane_cnt;
  assign trail_done   = (state_current == TRAIL) && (cnt == '0);

  always_comb begin
    state_next = state_current;
    load_cnt   = 1'b0;
    load_val   = '0;
    case (state_current)
      IDLE: if (start_rqst) begin
        state_next = GO;
        load_cnt   = 1'b1;
        load_val   = load_of(hs_go_timeout);
      end
      GO: if (cnt == '0) state_next = (CLK_MODE != 0) ? ACTIVE : SYNC;
      SYNC: state_next = ACTIVE;
      ACTIVE: if (fin_rqst) begin
        state_next = TRAIL;
        load_cnt   = 1'b1;
        load_val   = load_of(hs_trail_timeout);
      end
`ifdef DSI_HS_EXIT_TIMER_EN
      TRAIL: if (cnt == '0) begin
        state_next = EXIT;
        load_cnt   = 1'b1;
        load_val   = load_of(hs_exit_timeout);
      end
      EXIT: if (cnt == '0) state_next = IDLE;
`else
      TRAIL: if (cnt == '0) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Per-lane byte selection; lanes above the latched count stay silent for the burst.
  always_comb begin
    lane_en     = '0;
    out_next    = '0;
    enable_next = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_en[i] = (2'(i) <= lane_q);
      case (state_current)
        SYNC:    out_next[8*i +: 8] = 8'h1D;
        ACTIVE:  out_next[8*i +: 8] = inp_data[8*i +: 8];
        TRAIL:   out_next[8*i +: 8] = {8{~last_b7[i]}};
        default: out_next[8*i +: 8] = 8'h00;
      endcase
      if (!lane_en[i]) out_next[8*i +: 8] = 8'h00;
`ifdef DSI_HS_EXIT_TIMER_EN
      enable_next[i] = lane_en[i] && (state_current != IDLE) && (state_current != EXIT);
`else
      enable_next[i] = lane_en[i] && (state_current != IDLE);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_current <= IDLE;
      cnt           <= '0;
      lane_q        <= MAX_LANE;
      last_b7       <= '0;
      data_rqst     <= 1'b0;
      active        <= 1'b0;
      fin_ack       <= 1'b0;
      hs_output     <= '0;
      hs_enable     <= '0;
    end else begin
      state_current <= state_next;
      if (load_cnt)
        cnt <= load_val;
      else if (cnt != '0)
        cnt <= cnt - TIMER_W'(1);
      if ((state_current == IDLE) && start_rqst)
        lane_q <= lane_clamped;
      // Trail polarity follows the final payload bit on the wire (MSB, sent last).
      if (state_current == ACTIVE)
        for (int i = 0; i < LANES; i++) last_b7[i] <= inp_data[8*i+7];
      data_rqst <= (state_next == ACTIVE) && !fin_rqst;
      if (state_next == GO)
        active <= 1'b1;
      else if (state_next == IDLE)
        active <= 1'b0;
      fin_ack   <= trail_done;
      hs_output <= out_next;
      hs_enable <= enable_next;
    end
  end

endmodule

// File: tb/tb_dsi_hs_multilane_tx.sv
// Directed bench for dsi_hs_multilane_tx: 4-lane main DUT, a 2-lane clamp DUT and a 1-lane clock-mode DUT.
// Honours DSI_HS_EXIT_TIMER_EN by checking the EXIT interval when defined.
module tb_dsi_hs_multilane_tx;

  localparam int TW = 8;
`ifdef DSI_HS_EXIT_TIMER_EN
  localparam logic EXIT_EN = 1'b1;
`else
  localparam logic EXIT_EN = 1'b0;
`endif

  logic          clk, rst_n, start_rqst, fin_rqst;
  logic [1:0]    lane_cnt;
  logic [31:0]   inp_data;
  logic [TW-1:0] hs_go_timeout, hs_trail_timeout;
`ifdef DSI_HS_EXIT_TIMER_EN
  logic [TW-1:0] hs_exit_timeout;
`endif

  logic          data_rqst, active, fin_ack;
  logic [31:0]   hs_output;
  logic [3:0]    hs_enable;
  logic          d2_data_rqst, d2_active, d2_fin_ack;
  logic [15:0]   d2_hs_output;
  logic [1:0]    d2_hs_enable;
  logic          c_data_rqst, c_active, c_fin_ack;
  logic [7:0]    c_hs_output;
  logic [0:0]    c_hs_enable;

  int n_checks;
  int n_errors;

  dsi_hs_multilane_tx #(.LANES(4), .CLK_MODE(0), .TIMER_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start_rqst(start_rqst), .fin_rqst(fin_rqst),
    .lane_cnt(lane_cnt), .inp_data(inp_data),
    .hs_go_timeout(hs_go_timeout), .hs_trail_timeout(hs_trail_timeout),
`ifdef DSI_HS_EXIT_TIMER_EN
    .hs_exit_timeout(hs_exit_timeout),
`endif
    .data_rqst(data_rqst), .active(active), .fin_ack(fin_ack),
    .hs_output(hs_output), .hs_enable(hs_enable)
  );

  dsi_hs_multilane_tx #(.LANES(2), .CLK_MODE(0), .TIMER_W(TW)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_rqst(start_rqst), .fin_rqst(fin_rqst),
    .lane_cnt(lane_cnt), .inp_data(inp_data[15:0]),
    .hs_go_timeout(hs_go_timeout), .hs_trail_timeout(hs_trail_timeout),
`ifdef DSI_HS_EXIT_TIMER_EN
    .hs_exit_timeout(hs_exit_timeout),
`endif
    .data_rqst(d2_data_rqst), .active(d2_active), .fin_ack(d2_fin_ack),
    .hs_output(d2_hs_output), .hs_enable(d2_hs_enable)
  );

  dsi_hs_multilane_tx #(.LANES(1), .CLK_MODE(1), .TIMER_W(TW)) dutc (
    .clk(clk), .rst_n(rst_n), .start_rqst(start_rqst), .fin_rqst(fin_rqst),
    .lane_cnt(lane_cnt), .inp_data(inp_data[7:0]),
    .hs_go_timeout(hs_go_timeout), .hs_trail_timeout(hs_trail_timeout),
`ifdef DSI_HS_EXIT_TIMER_EN
    .hs_exit_timeout(hs_exit_timeout),
`endif
    .data_rqst(c_data_rqst), .active(c_active), .fin_ack(c_fin_ack),
    .hs_output(c_hs_output), .hs_enable(c_hs_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic [31:0] d);
    start_rqst = s;
    fin_rqst   = f;
    inp_data   = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    lane_cnt         = 2'd3;
    hs_go_timeout    = 8'd3;
    hs_trail_timeout = 8'd2;
`ifdef DSI_HS_EXIT_TIMER_EN
    hs_exit_timeout  = 8'd4;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hs_output", hs_output, 32'h0);
    checkOutput("rst_hs_enable", 32'(hs_enable), 32'h0);
    checkOutput("rst_active", 32'(active), 32'h0);
    checkOutput("rst_data_rqst", 32'(data_rqst), 32'h0);
    checkOutput("rst_fin_ack", 32'(fin_ack), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Burst 1: 4 lanes, go=3, trail=2; start in cycle 0
    applyStimulus(1'b1, 1'b0, 32'h0);
    step();                                           // cycle 1
    checkOutput("b1_active_c1", 32'(active), 32'h1);
    checkOutput("b1_en_lag_c1", 32'(hs_enable), 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0);                 // fin during GO must be ignored
    step();                                           // cycle 2
    checkOutput("b1_en_c2", 32'(hs_enable), 32'hF);
    checkOutput("d2_en_clamp", 32'(d2_hs_enable), 32'h3);
    checkOutput("c_en_c2", 32'(c_hs_enable), 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    step();                                           // cycle 3
    step();                                           // cycle 4 (SYNC)
    checkOutput("b1_out_c4", hs_output, 32'h0);
    checkOutput("b1_drq_c4", 32'(data_rqst), 32'h0);
    checkOutput("c_drq_c4", 32'(c_data_rqst), 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0000_0055);
    step();                                           // cycle 5
    checkOutput("b1_sync_c5", hs_output, 32'h1D1D1D1D);
    checkOutput("b1_drq_c5", 32'(data_rqst), 32'h1);
    checkOutput("d2_sync_c5", 32'(d2_hs_output), 32'h1D1D);
    checkOutput("d2_drq_c5", 32'(d2_data_rqst), 32'h1);
    checkOutput("c_nosync_c5", 32'(c_hs_output), 32'h55);
    applyStimulus(1'b0, 1'b0, 32'h44332211);
    step();                                           // cycle 6
    checkOutput("b1_data_c6", hs_output, 32'h44332211);
    checkOutput("d2_data_c6", 32'(d2_hs_output), 32'h2211);
    checkOutput("c_data_c6", 32'(c_hs_output), 32'h11);
    applyStimulus(1'b0, 1'b1, 32'hFF007F80);
    step();                                           // cycle 7 (TRAIL)
    checkOutput("b1_last_c7", hs_output, 32'hFF007F80);
    checkOutput("b1_drq_c7", 32'(data_rqst), 32'h0);
    checkOutput("b1_ack_c7", 32'(fin_ack), 32'h0);
    checkOutput("b1_active_c7", 32'(active), 32'h1);
    applyStimulus(1'b0, 1'b0, 32'hAAAAAAAA);
    step();                                           // cycle 8
    checkOutput("b1_trail_c8", hs_output, 32'h00FFFF00);
    checkOutput("b1_ack_c8", 32'(fin_ack), 32'h0);
    step();                                           // cycle 9 (IDLE or EXIT)
    checkOutput("b1_ack_c9", 32'(fin_ack), 32'h1);
    checkOutput("d2_ack_c9", 32'(d2_fin_ack), 32'h1);
    checkOutput("c_ack_c9", 32'(c_fin_ack), 32'h1);
    checkOutput("b1_active_c9", 32'(active), 32'(EXIT_EN));
    checkOutput("d2_active_c9", 32'(d2_active), 32'(EXIT_EN));
    checkOutput("c_active_c9", 32'(c_active), 32'(EXIT_EN));
    checkOutput("b1_trail_c9", hs_output, 32'h00FFFF00);
    checkOutput("b1_en_c9", 32'(hs_enable), 32'hF);

    // Burst 2: lane_cnt=1, zero timeouts; start in the first IDLE cycle
    lane_cnt         = 2'd1;
    hs_go_timeout    = 8'd0;
    hs_trail_timeout = 8'd0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    step();                                           // cycle 10
    checkOutput("b1_ack_c10", 32'(fin_ack), 32'h0);
    checkOutput("b1_en_c10", 32'(hs_enable), 32'h0);
    checkOutput("b1_out_c10", hs_output, 32'h0);
    checkOutput("b2_active_1", 32'(active), 32'h1);
`ifdef DSI_HS_EXIT_TIMER_EN
    // start held high through EXIT; accepted only once IDLE is reached in cycle 13
    for (int c = 11; c <= 12; c++) begin
      step();
      checkOutput("exit_active", 32'(active), 32'h1);
      checkOutput("exit_en", 32'(hs_enable), 32'h0);
    end
    step();                                           // cycle 13 (IDLE)
    checkOutput("exit_done_active", 32'(active), 32'h0);
    checkOutput("exit_done_en", 32'(hs_enable), 32'h0);
    step();
    checkOutput("b2_active_1x", 32'(active), 32'h1);
`endif
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("b2_en_1", 32'(hs_enable), 32'h0);
    step();                                           // 2' (SYNC)
    checkOutput("b2_en_2", 32'(hs_enable), 32'h3);
    checkOutput("b2_out_2", hs_output, 32'h0);
    step();                                           // 3' (ACTIVE)
    checkOutput("b2_sync_3", hs_output, 32'h00001D1D);
    checkOutput("b2_drq_3", 32'(data_rqst), 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h99887766);
    step();                                           // 4' (TRAIL)
    checkOutput("b2_data_4", hs_output, 32'h00007766);
    checkOutput("b2_drq_4", 32'(data_rqst), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    step();                                           // 5'
    checkOutput("b2_ack_5", 32'(fin_ack), 32'h1);
    checkOutput("b2_active_5", 32'(active), 32'(EXIT_EN));
    checkOutput("b2_trail_5", hs_output, 32'h0000FFFF);
    checkOutput("b2_en_5", 32'(hs_enable), 32'h3);
    step();                                           // 6'
    checkOutput("b2_ack_6", 32'(fin_ack), 32'h0);
    checkOutput("b2_en_6", 32'(hs_enable), 32'h0);
    repeat (6) step();

    // Burst 3: asynchronous reset in the middle of ACTIVE
    lane_cnt         = 2'd3;
    hs_go_timeout    = 8'd1;
    hs_trail_timeout = 8'd1;
    applyStimulus(1'b1, 1'b0, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
    step();
    step();
    applyStimulus(1'b0, 1'b0, 32'h12345678);
    step();
    checkOutput("b3_data", hs_output, 32'h12345678);
    checkOutput("b3_active", 32'(active), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("b3_rst_out", hs_output, 32'h0);
    checkOutput("b3_rst_en", 32'(hs_enable), 32'h0);
    checkOutput("b3_rst_active", 32'(active), 32'h0);
    checkOutput("b3_rst_drq", 32'(data_rqst), 32'h0);
    checkOutput("b3_rst_d2_en", 32'(d2_hs_enable), 32'h0);
    #2 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    step();
    checkOutput("b3_no_ack_1", 32'(fin_ack), 32'h0);
    checkOutput("b3_idle_active", 32'(active), 32'h0);
    step();
    checkOutput("b3_no_ack_2", 32'(fin_ack), 32'h0);

    // Burst 4: normal burst after reset, go=2, trail=3
    hs_go_timeout    = 8'd2;
    hs_trail_timeout = 8'd3;
    applyStimulus(1'b1, 1'b0, 32'h0);
    step();                                           // c1
    applyStimulus(1'b0, 1'b0, 32'h0);
    step();                                           // c2
    step();                                           // c3 (SYNC)
    checkOutput("b4_out_c3", hs_output, 32'h0);
    step();                                           // c4
    checkOutput("b4_sync_c4", hs_output, 32'h1D1D1D1D);
    applyStimulus(1'b0, 1'b1, 32'h0102A3F4);
    step();                                           // c5
    checkOutput("b4_data_c5", hs_output, 32'h0102A3F4);
    applyStimulus(1'b0, 1'b0, 32'h0);
    step();                                           // c6
    checkOutput("b4_trail_c6", hs_output, 32'hFFFF0000);
    step();                                           // c7
    checkOutput("b4_ack_c7", 32'(fin_ack), 32'h0);
    step();                                           // c8
    checkOutput("b4_ack_c8", 32'(fin_ack), 32'h1);
    checkOutput("b4_active_c8", 32'(active), 32'(EXIT_EN));
    step();                                           // c9
    checkOutput("b4_ack_c9", 32'(fin_ack), 32'h0);
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
